pipe_reg_skid: RTL
==================

# pipe_reg_skid

Parametrised pipeline stage register with valid/ready handshake, synchronous flush and an optional skid buffer. It replaces the plain enable-style inter-stage registers of the MIPS datapath (IF/ID, ID/EX, EX/MEM, MEM/WB). Stalls propagate through back-pressure (`out_ready` low) instead of a global enable. Hazard logic squashes a stage through `flush`.

## Interface
- `WIDTH`, 32, payload width in bits (≥1)
- `RESET_DATA`, 0, value loaded into `out_data` on reset (WIDTH bits)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  reset, synchronous, active-high; clock clk
- `flush`  in  1  synchronous squash of all held entries
- `in_valid`  in  1  upstream payload valid
- `in_ready`  out  1  stage can accept a payload this cycle
- `in_data`  in  WIDTH  upstream payload
- `out_valid`  out  1  payload available downstream
- `out_ready`  in  1  downstream accepts payload this cycle
- `out_data`  out  WIDTH  payload to downstream
- `count`  out  2  entries held (0..2; max 1 without skid)

## Operation
- Handshakes:
  - Accept when `in_valid && in_ready`.
  - Emit when `out_valid && out_ready`.
- Storage:
  - Main register (drives `out_*`).
  - Skid register (only with skid buffer compiled in).
- States (skid build): EMPTY (count 0), ONE (count 1), FULL (count 2).
- EMPTY:
  - accept → main←in_data, go to ONE.
  - no accept → stay.
- ONE:
  - accept+emit → main←in_data, stay ONE.
  - accept only → skid←in_data, go to FULL.
  - emit only → go to EMPTY.
  - neither → hold.
- FULL:
  - `in_ready`=0.
  - emit → main←skid, go to ONE.
  - no emit → hold.
- `in_ready` (skid build) = registered `!FULL`; no combinational path from `out_ready`.
- Ordering is strictly FIFO; no payload is dropped or duplicated except by flush or reset.
- Priority: reset > flush > handshake transfers.
- Flush:
  - Next state EMPTY, `out_valid`=0, `count`=0.
  - A payload offered in the flush cycle is discarded even if `in_ready`=1.
  - Data registers keep their contents.
- Data registers load only on the transfers above; otherwise they hold. This is required for power and for stable `out_data` under stall.
- `out_data` is stable while `out_valid && !out_ready`; the bench asserts this.

## Timing
- Latency: accepted at edge N → `out_valid`/`out_data` visible after edge N, emittable in cycle N+1.
- Throughput: 1 payload/cycle in steady state.
- Reset values (while `reset` high and after the reset edge):
  - `out_valid`=0, `out_data`=RESET_DATA, `count`=0.
  - `in_ready`=0 while `reset` is high; 1 in the first cycle after release.
  - Skid contents are don't-care.
- Reset mid-operation: all held payloads are lost; no emission occurs in the reset cycle.
- Skid build: FULL→ONE on emit re-raises `in_ready` one cycle later, so worst case is one bubble after back-pressure releases.
- No-skid build: `in_ready` = `!out_valid || out_ready` (combinational). No bubble, but a long ready path.

## Configuration
- `PIPE_REG_SKID_EN` defined:
  - Skid register and FULL state present.
  - `in_ready` registered.
  - `count` ranges 0..2.
- `PIPE_REG_SKID_EN` undefined:
  - Single register, states EMPTY/ONE only.
  - `in_ready` combinational as above.
  - `count[1]` tied 0.
  - Handshake and flush semantics otherwise identical.

## Structure
- Shared package `pipe_pkg`:
  - State enum `pipe_state_t` {EMPTY, ONE, FULL}.
  - Constant `PIPE_DEFAULT_WIDTH`=32.
  - Count width constant `PIPE_CNT_W`=2.
- Sub-module `pipe_data_reg`: WIDTH-wide register with load enable and synchronous reset to a parameter value.
  - Instantiated for main (reset to RESET_DATA) and skid (no reset needed; tie reset 0).
- Control FSM and handshake logic are in `pipe_reg_skid` itself.

## Test plan
- Reset:
  - Hold `reset` 3 cycles with `in_valid`=1, `in_data`=0xDEADBEEF → `out_valid`=0, `out_data`=0, `count`=0, `in_ready`=0 throughout.
  - `in_ready`=1 on the first cycle after release.
- Streaming: `out_ready`=1, send 0x1,0x2,0x3 back-to-back → emitted 0x1,0x2,0x3 on consecutive cycles, each one cycle after acceptance; `count` stays 1.
- Back-pressure (skid build):
  - `out_ready`=0, send 0xA then 0xB → `count`=2, `in_ready`=0, `out_data`=0xA held stable.
  - Raise `out_ready` → 0xA, then 0xB emitted in order; `in_ready` returns to 1 one cycle after 0xA leaves.
- Flush:
  - In FULL, assert `flush` with `in_valid`=1, `in_data`=0xC → next cycle `out_valid`=0, `count`=0.
  - 0xA, 0xB and 0xC are never emitted.
- Reset mid-operation: assert `reset` in ONE holding 0x55 with `out_ready`=0 → next cycle `out_valid`=0, `out_data`=RESET_DATA; 0x55 never emitted.
- No-skid build: `out_ready`=0 with `out_valid`=1 → `in_ready`=0 in the same cycle; raise `out_ready` → `in_ready`=1 in the same cycle, and a new payload is accepted while the old one is emitted.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the valid/ready pipeline stage registers.
package pipe_pkg;

    localparam int unsigned PIPE_DEFAULT_WIDTH = 32;
    localparam int unsigned PIPE_CNT_W         = 2;

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable and synchronous reset to a parameter value.
module pipe_data_reg
    import pipe_pkg::*;
#(
    parameter int unsigned    WIDTH     = PIPE_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_reg_skid.sv
// Pipeline stage register with valid/ready handshake, flush and optional skid buffer.
// Build option: define PIPE_REG_SKID_EN for the skid register and a registered in_ready.
module pipe_reg_skid
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH      = PIPE_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [PIPE_CNT_W-1:0] count
);

    pipe_state_t      state;
    pipe_state_t      state_nxt;
    logic             accept;
    logic             emit;
    logic             main_load;
    logic [WIDTH-1:0] main_d;
`ifdef PIPE_REG_SKID_EN
    logic             skid_load;
    logic [WIDTH-1:0] skid_q;
`endif

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

`ifdef PIPE_REG_SKID_EN
    // Ready depends only on the state register, never on out_ready.
    assign in_ready = !reset && (state != FULL);
    assign count    = PIPE_CNT_W'(state);
`else
    assign in_ready = !reset && (!out_valid || out_ready);
    assign count    = {1'b0, state[0]};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and data-register load strobes; flush outranks every transfer.
    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        main_d    = in_data;
`ifdef PIPE_REG_SKID_EN
        skid_load = 1'b0;
`endif
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (accept) begin
                        if (emit) begin
                            main_load = 1'b1;
                        end
`ifdef PIPE_REG_SKID_EN
                        else begin
                            skid_load = 1'b1;
                            state_nxt = FULL;
                        end
`endif
                    end else if (emit) begin
                        state_nxt = EMPTY;
                    end
                end
`ifdef PIPE_REG_SKID_EN
                FULL: begin
                    if (emit) begin
                        main_load = 1'b1;
                        main_d    = skid_q;
                        state_nxt = ONE;
                    end
                end
`endif
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_DATA)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .d     (main_d),
        .q     (out_data)
    );

`ifdef PIPE_REG_SKID_EN
    // Skid contents are don't-care after reset, so it carries no reset.
    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL ('0)
    ) u_skid (
        .clk   (clk),
        .reset (1'b0),
        .load  (skid_load),
        .d     (in_data),
        .q     (skid_q)
    );
`endif

endmodule
